aes_axis_ingest: RTL and testbench

AXI-Stream slave front end that feeds the AES controller's input FIFO. It receives 32-bit beats from the DMA, latches the leading command word onto aes_cmd, and packs the following words into 128-bit FIFO entries (key halves, IV, data blocks) on a valid/ready write port. It asserts axis_slave_done at end of frame and holds off the next frame until the controller reports processing_done.

---
 rtl/aes_axis_ingest_pkg.sv | 15 +
 rtl/aes_axis_ingest_if.sv | 33 +++
 rtl/aes_axis_ingest_packer.sv | 40 ++++
 rtl/aes_axis_ingest.sv | 127 ++++++++++++
 tb/tb_aes_axis_ingest.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_axis_ingest_pkg.sv
// Shared widths and FSM state type for the AES AXI-Stream ingest front end.
package aes_axis_ingest_pkg;

   // Command / stream beat width and FIFO entry (AES block) width.
   localparam int WORD_S = 32;
   localparam int BLK_S  = 128;

   typedef enum logic [1:0] {
      S_CMD  = 2'd0,   // waiting for the leading command word
      S_PACK = 2'd1,   // collecting words into the current entry
      S_PUSH = 2'd2,   // holding a completed entry on the FIFO write port
      S_DONE = 2'd3    // frame complete, waiting for the controller
   } ingest_state_e;

endpackage

// File: rtl/aes_axis_ingest_if.sv
// Stream input, FIFO write port and controller handshake of the ingest block.
interface aes_axis_ingest_if #(
   parameter int AXIS_DATA_WIDTH = aes_axis_ingest_pkg::WORD_S,
   parameter int FIFO_DATA_WIDTH = aes_axis_ingest_pkg::BLK_S
) ();
   logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata;
   logic                       s_axis_tvalid;
   logic                       s_axis_tlast;
   logic                       s_axis_tready;
   logic [AXIS_DATA_WIDTH-1:0] aes_cmd;
   logic [FIFO_DATA_WIDTH-1:0] in_fifo_data;
   logic                       in_fifo_write_tvalid;
   logic                       in_fifo_write_tready;
   logic                       axis_slave_done;
   logic                       processing_done;
   logic                       frame_pad;

   // Ingest block side.
   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      input  in_fifo_write_tready, processing_done,
      output s_axis_tready, aes_cmd, in_fifo_data, in_fifo_write_tvalid,
      output axis_slave_done, frame_pad
   );

   // DMA / FIFO / controller side.
   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      output in_fifo_write_tready, processing_done,
      input  s_axis_tready, aes_cmd, in_fifo_data, in_fifo_write_tvalid,
      input  axis_slave_done, frame_pad
   );
endinterface

// File: rtl/aes_axis_ingest_packer.sv
// Packs stream words into one FIFO entry, first word in the MSBs.
// The accumulator is cleared after every completed entry, so slots not yet
// written in the current entry always read as zero (zero padding for free).
module aes_axis_ingest_packer #(
   parameter int W     = 32,
   parameter int N     = 4,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,        // start of a new frame
   input  logic             wr,         // word accepted into the entry
   input  logic             flush,      // this word completes the entry
   input  logic [W-1:0]     word,
   output logic [CNT_W-1:0] word_cnt,
   output logic             last_slot,
   output logic [N*W-1:0]   entry       // accumulator with current word merged in
);
   logic [N-1:0][W-1:0] acc_q;
   logic [N-1:0][W-1:0] entry_w;

   assign last_slot = (word_cnt == CNT_W'(N-1));
   assign entry     = entry_w;

   // Slot s lives at packed index N-1-s so slot 0 lands in the top bits.
   for (genvar k = 0; k < N; k++) begin : g_slot
      assign entry_w[k] = (word_cnt == CNT_W'(N-1-k)) ? word : acc_q[k];
   end

   // Accumulate words; drop everything on frame start or entry completion.
   always_ff @(posedge clk) begin
      if (reset || clr || (wr && flush)) begin
         acc_q    <= '0;
         word_cnt <= '0;
      end else if (wr) begin
         acc_q    <= entry_w;
         word_cnt <= word_cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/aes_axis_ingest.sv
// AXI-Stream slave front end for the AES controller input FIFO.
// First beat of a frame is the command; following beats are packed into
// FIFO entries. The block parks in S_DONE until the controller signals a
// rising edge on processing_done, which keeps the next frame out meanwhile.
module aes_axis_ingest
   import aes_axis_ingest_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH = WORD_S,
   parameter int FIFO_DATA_WIDTH = BLK_S
) (
   input  logic             clk,
   input  logic             reset,
   aes_axis_ingest_if.slave bus
);
   localparam int WORDS_PER_ENTRY = FIFO_DATA_WIDTH / AXIS_DATA_WIDTH;
   localparam int CNT_W = (WORDS_PER_ENTRY > 1) ? $clog2(WORDS_PER_ENTRY) : 1;

   ingest_state_e              state_q, state_d;
   logic [AXIS_DATA_WIDTH-1:0] cmd_q, cmd_d;
   logic [FIFO_DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
   logic                       fifo_vld_q, fifo_vld_d;
   logic                       done_q, done_d;
   logic                       pad_q, pad_d;
   logic                       last_q, last_d;
   logic                       pd_q;

   logic                       beat, push, pd_rise;
   logic                       pk_wr, pk_clr, pk_flush, pk_last_slot;
   logic [CNT_W-1:0]           word_cnt;
   logic [FIFO_DATA_WIDTH-1:0] pk_entry;

   // Ready only while collecting; held low in reset so nothing slips in.
   assign bus.s_axis_tready = !reset && (state_q == S_CMD || state_q == S_PACK);

   assign beat     = bus.s_axis_tvalid && bus.s_axis_tready;
   assign push     = fifo_vld_q && bus.in_fifo_write_tready;
   assign pd_rise  = bus.processing_done && !pd_q;
   assign pk_clr   = beat && (state_q == S_CMD);
   assign pk_wr    = beat && (state_q == S_PACK);
   assign pk_flush = pk_last_slot || bus.s_axis_tlast;

   aes_axis_ingest_packer #(
      .W     (AXIS_DATA_WIDTH),
      .N     (WORDS_PER_ENTRY),
      .CNT_W (CNT_W)
   ) u_packer (
      .clk       (clk),
      .reset     (reset),
      .clr       (pk_clr),
      .wr        (pk_wr),
      .flush     (pk_flush),
      .word      (bus.s_axis_tdata),
      .word_cnt  (word_cnt),
      .last_slot (pk_last_slot),
      .entry     (pk_entry)
   );

   // Next state and next values of all registered outputs.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      fifo_data_d = fifo_data_q;
      fifo_vld_d  = fifo_vld_q;
      last_d      = last_q;
      pad_d       = 1'b0;
      case (state_q)
         S_CMD: begin
            if (beat) begin
               cmd_d   = bus.s_axis_tdata;
               state_d = bus.s_axis_tlast ? S_DONE : S_PACK;
            end
         end
         S_PACK: begin
            if (beat && pk_flush) begin
               fifo_data_d = pk_entry;
               fifo_vld_d  = 1'b1;
               last_d      = bus.s_axis_tlast;
               pad_d       = bus.s_axis_tlast && !pk_last_slot;
               state_d     = S_PUSH;
            end
         end
         S_PUSH: begin
            if (push) begin
               fifo_vld_d = 1'b0;
               state_d    = last_q ? S_DONE : S_PACK;
            end
         end
         S_DONE: begin
            if (pd_rise) state_d = S_CMD;
         end
         default: begin
            fifo_vld_d = 1'b0;
            state_d    = S_CMD;
         end
      endcase
      done_d = (state_d == S_DONE);
   end

   // State and output registers; pd_q tracks processing_done for edge detect.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_CMD;
         cmd_q       <= '0;
         fifo_data_q <= '0;
         fifo_vld_q  <= 1'b0;
         done_q      <= 1'b0;
         pad_q       <= 1'b0;
         last_q      <= 1'b0;
         pd_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         fifo_data_q <= fifo_data_d;
         fifo_vld_q  <= fifo_vld_d;
         done_q      <= done_d;
         pad_q       <= pad_d;
         last_q      <= last_d;
         pd_q        <= bus.processing_done;
      end
   end

   assign bus.aes_cmd              = cmd_q;
   assign bus.in_fifo_data         = fifo_data_q;
   assign bus.in_fifo_write_tvalid = fifo_vld_q;
   assign bus.axis_slave_done      = done_q;
   assign bus.frame_pad            = pad_q;
endmodule

// File: tb/tb_aes_axis_ingest.sv
// Bench for aes_axis_ingest: directed frames plus randomized frames with
// random stream gaps and FIFO backpressure, checked against a word-list model.
`timescale 1ns/1ps
module tb_aes_axis_ingest;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   aes_axis_ingest_if #(.AXIS_DATA_WIDTH(32), .FIFO_DATA_WIDTH(128)) bus ();

   aes_axis_ingest #(.AXIS_DATA_WIDTH(32), .FIFO_DATA_WIDTH(128)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int           total = 0;
   int           bad   = 0;
   int           fifo_mode = 0;   // 0 always ready, 1 random, 2 stalled
   int           pad_cnt = 0;
   int           pad0 = 0;
   logic [127:0] got_q[$];
   logic [127:0] exp_q[$];
   logic [31:0]  wq[$];

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // FIFO sink: picks ready for the coming edge, logs entries that will be taken.
   initial begin
      bus.in_fifo_write_tready = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         case (fifo_mode)
            0:       bus.in_fifo_write_tready = 1'b1;
            1:       bus.in_fifo_write_tready = ($urandom_range(0, 2) != 0);
            default: bus.in_fifo_write_tready = 1'b0;
         endcase
         if (!reset && bus.in_fifo_write_tvalid && bus.in_fifo_write_tready)
            got_q.push_back(bus.in_fifo_data);
         if (bus.frame_pad) pad_cnt++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   // Reference: words in groups of four, first word in the top 32 bits, zero fill.
   task automatic build_exp();
      logic [127:0] e;
      exp_q.delete();
      for (int i = 0; i < wq.size(); i += 4) begin
         e = '0;
         for (int j = 0; j < 4; j++)
            if (i + j < wq.size()) e[127 - 32*j -: 32] = wq[i + j];
         exp_q.push_back(e);
      end
   endtask

   task automatic beat(input logic [31:0] d, input logic last, input bit gaps);
      int n;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.s_axis_tdata  = d;
      bus.s_axis_tlast  = last;
      bus.s_axis_tvalid = 1'b1;
      n = 0;
      while (!bus.s_axis_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("beat_timeout", 0, 1);
      @(negedge clk);
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] cmd, input bit gaps);
      beat(cmd, wq.size() == 0, gaps);
      foreach (wq[i]) beat(wq[i], i == wq.size() - 1, gaps);
   endtask

   task automatic start_frame();
      got_q.delete();
      pad0 = pad_cnt;
      build_exp();
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!bus.axis_slave_done && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, bus.axis_slave_done, 1);
   endtask

   task automatic end_frame(input string tag, input logic [31:0] cmd);
      wait_done({tag, "_done"});
      chk({tag, "_cmd"}, bus.aes_cmd, cmd);
      chk({tag, "_vld_idle"}, bus.in_fifo_write_tvalid, 0);
      chk({tag, "_nent"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_ent%0d", tag, i), got_q[i], exp_q[i]);
      chk({tag, "_pad"}, pad_cnt - pad0, (wq.size() % 4 != 0) ? 1 : 0);
   endtask

   task automatic run_frame(input logic [31:0] cmd, input bit gaps, input string tag);
      start_frame();
      send_frame(cmd, gaps);
      end_frame(tag, cmd);
   endtask

   // Rising edge on processing_done: done must drop and ready return next cycle.
   task automatic release_frame();
      bus.processing_done = 1'b1;
      @(negedge clk);
      chk("rel_done_clr", bus.axis_slave_done, 0);
      chk("rel_tready", bus.s_axis_tready, 1);
      bus.processing_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic bp_observe();
      int           n;
      bit           stable, rdy_lo;
      logic [127:0] d0;
      n = 0;
      stable = 1'b1;
      rdy_lo = 1'b1;
      while (!bus.in_fifo_write_tvalid && n < 100) begin
         @(negedge clk);
         n++;
      end
      d0 = bus.in_fifo_data;
      repeat (20) begin
         @(negedge clk);
         if (bus.in_fifo_data !== d0 || !bus.in_fifo_write_tvalid) stable = 1'b0;
         if (bus.s_axis_tready) rdy_lo = 1'b0;
      end
      chk("bp_data_stable", stable, 1);
      chk("bp_tready_low", rdy_lo, 1);
      chk("bp_first_entry", d0, exp_q[0]);
      fifo_mode = 0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_tready"}, bus.s_axis_tready, 0);
      chk({tag, "_cmd"}, bus.aes_cmd, 0);
      chk({tag, "_data"}, bus.in_fifo_data, 0);
      chk({tag, "_vld"}, bus.in_fifo_write_tvalid, 0);
      chk({tag, "_done"}, bus.axis_slave_done, 0);
      chk({tag, "_pad"}, bus.frame_pad, 0);
   endtask

   initial begin
      logic [31:0] ecb[$];
      bit          ok;
      int          n;
      bus.s_axis_tdata    = '0;
      bus.s_axis_tvalid   = 1'b0;
      bus.s_axis_tlast    = 1'b0;
      bus.processing_done = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      reset = 1'b0;
      @(negedge clk);
      chk("idle_tready", bus.s_axis_tready, 1);

      // ECB-128 frame: key then one data block.
      ecb = {32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
             32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
      wq = ecb;
      run_frame(32'h0000_0011, 1'b0, "ecb");
      chk("ecb_key", exp_q[0], 128'h000102030405060708090A0B0C0D0E0F);
      release_frame();

      // Same frame with the FIFO stalled for 20 cycles on the first push.
      fifo_mode = 2;
      start_frame();
      fork
         send_frame(32'h0000_0011, 1'b0);
         bp_observe();
      join
      end_frame("bp", 32'h0000_0011);
      release_frame();

      // Partial frame: six words, second entry half filled.
      wq = {32'hA0A0A0A1, 32'hA0A0A0A2, 32'hA0A0A0A3, 32'hA0A0A0A4,
            32'hB5B5B5B5, 32'hB6B6B6B6};
      run_frame(32'h0000_0022, 1'b0, "part");
      release_frame();

      // Command-only frame with processing_done already high.
      wq.delete();
      bus.processing_done = 1'b1;
      @(negedge clk);
      run_frame(32'h0000_0033, 1'b0, "cmdonly");
      repeat (5) @(negedge clk);
      chk("pdhigh_hold_done", bus.axis_slave_done, 1);
      chk("pdhigh_tready", bus.s_axis_tready, 0);
      bus.processing_done = 1'b0;
      @(negedge clk);
      release_frame();

      // Next frame offered while the previous one is still done.
      wq = {32'h11112222, 32'h33334444, 32'h55556666};
      run_frame(32'h0000_0044, 1'b0, "hold");
      bus.s_axis_tdata  = 32'h0000_0055;
      bus.s_axis_tlast  = 1'b1;
      bus.s_axis_tvalid = 1'b1;
      ok = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.s_axis_tready || bus.aes_cmd !== 32'h0000_0044) ok = 1'b0;
      end
      chk("hold_blocked", ok, 1);
      chk("hold_cmd", bus.aes_cmd, 32'h0000_0044);
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      release_frame();

      // Reset after two data words, then a clean frame.
      beat(32'h0000_0066, 1'b0, 1'b0);
      beat(32'hDEAD0001, 1'b0, 1'b0);
      beat(32'hDEAD0002, 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("midrst");
      reset = 1'b0;
      @(negedge clk);
      wq = {32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004, 32'hC0000005};
      run_frame(32'h0000_0077, 1'b0, "after_rst");
      release_frame();

      // Random frames with stream gaps and random FIFO ready.
      fifo_mode = 1;
      for (int f = 0; f < 12; f++) begin
         wq.delete();
         n = $urandom_range(0, 11);
         for (int i = 0; i < n; i++) wq.push_back($urandom);
         run_frame($urandom, 1'b1, $sformatf("rnd%0d", f));
         release_frame();
      end
      fifo_mode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
